// File: rtl/display_fill_arbiter_pkg.sv
// rtl/display_fill_arbiter_pkg.sv - shared widths, state encoding and row clamp helper
package display_fill_arbiter_pkg;
   localparam int ROW_W   = 7;
   localparam int COL_W   = 7;
   localparam int ADDR_W  = ROW_W + COL_W;
   localparam int COLOR_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   // Last row actually on screen for a requested last row.
   function automatic logic [ROW_W-1:0] clamp_row(input logic [ROW_W-1:0] row, input int rows);
      if (int'(row) > rows - 1)
         return ROW_W'(rows - 1);
      else
         return row;
   endfunction
endpackage

// File: rtl/display_fill_counter.sv
// rtl/display_fill_counter.sv - fill row/column counters with wrap and last-pixel detect
module display_fill_counter
   import display_fill_arbiter_pkg::*;
#(
   parameter int COLUMNS = 80
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [ROW_W-1:0] load_row,
   input  logic [ROW_W-1:0] load_last,
   input  logic             advance,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] column,
   output logic             at_last
);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLUMNS - 1);

   logic [ROW_W-1:0] last_row;

   always_ff @(posedge clk) begin
      if (reset) begin
         row      <= '0;
         column   <= '0;
         last_row <= '0;
      end else if (load) begin
         row      <= load_row;
         column   <= '0;
         last_row <= load_last;
      end else if (advance) begin
         if (column == COL_MAX) begin
            column <= '0;
            row    <= row + 1'b1;
         end else begin
            column <= column + 1'b1;
         end
      end
   end

   assign at_last = (row == last_row) && (column == COL_MAX);
endmodule

// File: rtl/display_fill_arbiter.sv
// rtl/display_fill_arbiter.sv - CPU-priority arbiter between CPU writes and a row-range fill engine
module display_fill_arbiter
   import display_fill_arbiter_pkg::*;
#(
   parameter int COLUMNS = 80,
   parameter int ROWS    = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cpuWrite,
   input  logic [ADDR_W-1:0]  cpuAddress,
   input  logic [COLOR_W-1:0] cpuData,
   input  logic               fillStart,
   input  logic [ROW_W-1:0]   fillRowFirst,
   input  logic [ROW_W-1:0]   fillRowLast,
   input  logic [COLOR_W-1:0] fillData,
   input  logic               fillAbort,
   output logic               fillBusy,
   output logic               fillDone,
   output logic               displayWrite,
   output logic [ADDR_W-1:0]  displayWriteAddress,
   output logic [COLOR_W-1:0] displayWriteData
);
   fill_state_t        state, next_state;
   logic [COLOR_W-1:0] fill_color;
   logic [ROW_W-1:0]   eff_last;
   logic [ROW_W-1:0]   row;
   logic [COL_W-1:0]   column;
   logic               at_last;
   logic               load;
   logic               engine_write;
   logic               done_next;

   assign eff_last = clamp_row(fillRowLast, ROWS);

   display_fill_counter #(.COLUMNS(COLUMNS)) u_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_row  (fillRowFirst),
      .load_last (eff_last),
      .advance   (engine_write),
      .row       (row),
      .column    (column),
      .at_last   (at_last)
   );

   always_comb begin
      next_state   = state;
      load         = 1'b0;
      engine_write = 1'b0;
      done_next    = 1'b0;
      case (state)
         IDLE: begin
            if (fillStart) begin
               load = 1'b1;
               // An empty row range completes immediately without touching the buffer.
               if (fillRowFirst > eff_last)
                  done_next = 1'b1;
               else
                  next_state = FILL;
            end
         end
         FILL: begin
            if (fillAbort) begin
               next_state = IDLE;
            end else if (!cpuWrite) begin
               engine_write = 1'b1;
               if (at_last) begin
                  next_state = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         fill_color          <= '0;
         fillBusy            <= 1'b0;
         fillDone            <= 1'b0;
         displayWrite        <= 1'b0;
         displayWriteAddress <= '0;
         displayWriteData    <= '0;
      end else begin
         state        <= next_state;
         fillBusy     <= (next_state == FILL);
         fillDone     <= done_next;
         displayWrite <= cpuWrite | engine_write;
         if (load)
            fill_color <= fillData;
         if (cpuWrite) begin
            displayWriteAddress <= cpuAddress;
            displayWriteData    <= cpuData;
         end else if (engine_write) begin
            displayWriteAddress <= {row, column};
            displayWriteData    <= fill_color;
         end
      end
   end
endmodule

// File: tb/tb_display_fill_arbiter.sv
// tb/tb_display_fill_arbiter.sv - directed self-checking bench for display_fill_arbiter
module tb_display_fill_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        cpuWrite;
   logic [13:0] cpuAddress;
   logic [2:0]  cpuData;
   logic        fillStart;
   logic [6:0]  fillRowFirst;
   logic [6:0]  fillRowLast;
   logic [2:0]  fillData;
   logic        fillAbort;
   logic        fillBusy;
   logic        fillDone;
   logic        displayWrite;
   logic [13:0] displayWriteAddress;
   logic [2:0]  displayWriteData;

   always #5 clk = ~clk;

   display_fill_arbiter #(.COLUMNS(80), .ROWS(30)) dut (
      .clk                 (clk),
      .reset               (reset),
      .cpuWrite            (cpuWrite),
      .cpuAddress          (cpuAddress),
      .cpuData             (cpuData),
      .fillStart           (fillStart),
      .fillRowFirst        (fillRowFirst),
      .fillRowLast         (fillRowLast),
      .fillData            (fillData),
      .fillAbort           (fillAbort),
      .fillBusy            (fillBusy),
      .fillDone            (fillDone),
      .displayWrite        (displayWrite),
      .displayWriteAddress (displayWriteAddress),
      .displayWriteData    (displayWriteData)
   );

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [13:0] wa[$];
   logic [2:0]  wd[$];
   int          done_count = 0;
   logic [13:0] done_addr = '0;
   logic        busy_seen = 1'b0;

   // Records every write strobe seen on the display port, away from the active edge.
   always @(negedge clk) begin
      if (displayWrite) begin
         wa.push_back(displayWriteAddress);
         wd.push_back(displayWriteData);
         if (fillDone) done_addr = displayWriteAddress;
      end
      if (fillDone) done_count++;
      if (fillBusy) busy_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      wa.delete();
      wd.delete();
      busy_seen = 1'b0;
   endtask

   task automatic start_fill(input logic [6:0] first, input logic [6:0] last, input logic [2:0] color);
      fillRowFirst = first;
      fillRowLast  = last;
      fillData     = color;
      fillStart    = 1'b1;
      tick();
      fillStart    = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, input string tag);
      int k;
      k = 0;
      while (done_count == base && k < budget) begin
         tick();
         k++;
      end
      chk({tag, "_timeout"}, 32'(k < budget), 32'd1);
      tick();
   endtask

   // Checks a run of engine writes against a row-major sequence starting at row_base.
   task automatic chk_seq(input string tag, input int first_row, input int rows, input logic [2:0] color);
      int bad;
      int exp_addr;
      bad = 0;
      for (int i = 0; i < wa.size(); i++) begin
         exp_addr = (first_row + i / 80) * 128 + (i % 80);
         if (wa[i] !== 14'(exp_addr) || wd[i] !== color) bad++;
      end
      chk({tag, "_count"}, 32'(wa.size()), 32'(rows * 80));
      chk({tag, "_seq_errors"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int base;
      int bad;
      int eng;

      reset        = 1'b1;
      cpuWrite     = 1'b1;
      cpuAddress   = 14'h3fff;
      cpuData      = 3'b111;
      fillStart    = 1'b1;
      fillRowFirst = '0;
      fillRowLast  = '0;
      fillData     = '0;
      fillAbort    = 1'b0;
      tick();
      tick();
      chk("rst_write", 32'(displayWrite), 32'd0);
      chk("rst_addr", 32'(displayWriteAddress), 32'd0);
      chk("rst_data", 32'(displayWriteData), 32'd0);
      chk("rst_busy", 32'(fillBusy), 32'd0);
      chk("rst_done", 32'(fillDone), 32'd0);
      reset     = 1'b0;
      cpuWrite  = 1'b0;
      fillStart = 1'b0;
      tick();

      // CPU write forwarded in IDLE; abort in IDLE does nothing.
      cpuWrite   = 1'b1;
      cpuAddress = 14'h0abc;
      cpuData    = 3'b110;
      fillAbort  = 1'b1;
      tick();
      cpuWrite   = 1'b0;
      fillAbort  = 1'b0;
      chk("cpu_idle_write", 32'(displayWrite), 32'd1);
      chk("cpu_idle_addr", 32'(displayWriteAddress), 32'h0abc);
      chk("cpu_idle_data", 32'(displayWriteData), 32'd6);
      chk("abort_idle_busy", 32'(fillBusy), 32'd0);
      tick();
      chk("cpu_idle_release", 32'(displayWrite), 32'd0);

      // Two full rows, no CPU traffic.
      clr();
      base = done_count;
      start_fill(7'd0, 7'd1, 3'b101);
      chk("t1_busy_after_start", 32'(fillBusy), 32'd1);
      wait_done(base, 300, "t1");
      chk_seq("t1", 0, 2, 3'b101);
      chk("t1_done_count", 32'(done_count - base), 32'd1);
      chk("t1_done_addr", 32'(done_addr), 32'd207);
      chk("t1_busy_end", 32'(fillBusy), 32'd0);

      // Row 2 with a stray fillStart and a 3-cycle CPU burst mid-row.
      clr();
      base = done_count;
      start_fill(7'd2, 7'd2, 3'b010);
      repeat (5) tick();
      start_fill(7'd0, 7'd0, 3'b001);
      repeat (4) tick();
      cpuWrite   = 1'b1;
      cpuAddress = 14'h0005;
      cpuData    = 3'b111;
      repeat (3) tick();
      cpuWrite   = 1'b0;
      wait_done(base, 300, "t2");
      chk("t2_count", 32'(wa.size()), 32'd83);
      chk("t2_cpu_first", 32'(wa[10]), 32'h0005);
      chk("t2_cpu_last", 32'(wa[12]), 32'h0005);
      chk("t2_cpu_data", 32'(wd[11]), 32'd7);
      chk("t2_resume", 32'(wa[13]), 32'd266);
      bad = 0;
      eng = 0;
      for (int i = 0; i < wa.size(); i++) begin
         if (i >= 10 && i <= 12) begin
            if (wa[i] !== 14'h0005 || wd[i] !== 3'b111) bad++;
         end else begin
            if (wa[i] !== 14'(256 + eng) || wd[i] !== 3'b010) bad++;
            eng++;
         end
      end
      chk("t2_seq_errors", 32'(bad), 32'd0);
      chk("t2_done_addr", 32'(done_addr), 32'd335);

      // Empty range: first row beyond last row.
      clr();
      base = done_count;
      start_fill(7'd5, 7'd3, 3'b001);
      chk("t3_done_pulse", 32'(fillDone), 32'd1);
      chk("t3_busy", 32'(fillBusy), 32'd0);
      tick();
      chk("t3_done_clear", 32'(fillDone), 32'd0);
      repeat (3) tick();
      chk("t3_writes", 32'(wa.size()), 32'd0);
      chk("t3_busy_seen", 32'(busy_seen), 32'd0);
      chk("t3_done_count", 32'(done_count - base), 32'd1);

      // Last row clamped to ROWS-1.
      clr();
      base = done_count;
      start_fill(7'd29, 7'd100, 3'b011);
      wait_done(base, 300, "t4");
      chk_seq("t4", 29, 1, 3'b011);
      chk("t4_done_addr", 32'(done_addr), 32'd3791);

      // Abort after 10 engine writes, then a fresh fill.
      clr();
      base = done_count;
      start_fill(7'd3, 7'd4, 3'b110);
      chk("t5_busy", 32'(fillBusy), 32'd1);
      repeat (10) tick();
      fillAbort = 1'b1;
      tick();
      fillAbort = 1'b0;
      chk("t5_busy_drop", 32'(fillBusy), 32'd0);
      repeat (3) tick();
      chk("t5_writes", 32'(wa.size()), 32'd10);
      chk("t5_last_addr", 32'(wa[9]), 32'd393);
      chk("t5_no_done", 32'(done_count - base), 32'd0);
      clr();
      start_fill(7'd6, 7'd6, 3'b100);
      chk("t5_restart_busy", 32'(fillBusy), 32'd1);
      wait_done(base, 300, "t5");
      chk_seq("t5_restart", 6, 1, 3'b100);

      // Reset mid-fill with CPU write and fillStart asserted.
      clr();
      base = done_count;
      start_fill(7'd0, 7'd5, 3'b111);
      repeat (20) tick();
      reset      = 1'b1;
      cpuWrite   = 1'b1;
      cpuAddress = 14'h1234;
      cpuData    = 3'b101;
      fillStart  = 1'b1;
      tick();
      chk("t6_write", 32'(displayWrite), 32'd0);
      chk("t6_addr", 32'(displayWriteAddress), 32'd0);
      chk("t6_data", 32'(displayWriteData), 32'd0);
      chk("t6_busy", 32'(fillBusy), 32'd0);
      chk("t6_done", 32'(fillDone), 32'd0);
      reset     = 1'b0;
      cpuWrite  = 1'b0;
      fillStart = 1'b0;
      repeat (5) tick();
      chk("t6_idle_busy", 32'(fillBusy), 32'd0);
      chk("t6_writes", 32'(wa.size()), 32'd20);
      chk("t6_no_done", 32'(done_count - base), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
